gauss_datapath: RTL and testbench
=================================

GAUSS_DATAPATH -- requirements
Module: gauss_datapath

Interface
REQ-001 Parameter WIDTH, default 8: operand width n; the result is 2*WIDTH bits wide.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 preset  input  1  synchronous, active-high reset.
REQ-004 ctrlword  input  3  one-hot command from the Gauss control unit: [0] LOAD, [1] ACCUM, [2] DONE.
REQ-005 op_valid  input  1  operand offered by the issue stage.
REQ-006 op_ready  output  1  operand can be accepted this cycle.
REQ-007 op_n  input  WIDTH  operand n; the block computes 1+2+...+n.
REQ-008 status  output  2  to the control unit: [1] iterations remain, [0] operand held.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 result  output  2*WIDTH  sum of 1..n.

Function
REQ-012 Internal state SHALL be: cnt (WIDTH bits), acc (2*WIDTH bits), held (1 bit), res_valid (1 bit) and the result register.
REQ-013 op_ready SHALL equal (ctrlword==001) & ~held & ~res_valid, combinationally.
REQ-014 Operand accept SHALL occur on an edge with op_valid & op_ready.
  - If op_n != 0: cnt<=op_n, acc<=0, held<=1.
  - If op_n == 0: result<=0, res_valid<=1, held stays 0.
REQ-015 status[0] SHALL equal held.
REQ-016 status[1] SHALL equal held & (cnt != 0).
  - Both status bits are combinational from the registers.
REQ-017 ACCUM with cnt != 0 SHALL perform acc<=acc+zero-extended cnt and cnt<=cnt-1.
REQ-018 ACCUM with cnt == 0 SHALL change no register.
REQ-019 DONE with held=1 and res_valid=0 SHALL perform result<=acc, res_valid<=1, held<=0.
  - In any other DONE condition, no register changes.
REQ-020 A non-one-hot ctrlword (including 000) SHALL freeze all of cnt, acc, held and result, and SHALL force op_ready=0.
REQ-021 res_valid SHALL clear on any edge with res_valid & res_ready, independent of ctrlword.
  - result SHALL hold its value until overwritten by the next completion.
REQ-022 result SHALL remain stable while res_valid=1.
REQ-023 There SHALL be a single result buffer: no new operand is accepted while res_valid=1.
REQ-024 Arithmetic SHALL never wrap: the maximum sum (2^WIDTH-1)*2^WIDTH/2 fits in 2*WIDTH bits.
REQ-025 Latency: operand accepted at edge k, plus n ACCUM edges, plus 1 DONE edge gives res_valid=1 after edge k+n+1.
  - Exception: n=0 gives res_valid=1 after edge k.
REQ-026 If a completion and a res_valid&res_ready handshake fall on the same edge, the handshake applies to the old result.
  - Because REQ-019 requires res_valid=0 for a completion, this case cannot arise; the bench SHALL assert it never occurs.

Reset
REQ-027 preset=1 at an edge SHALL set cnt=0, acc=0, held=0, res_valid=0, result=0.
  - preset overrides ctrlword, op_valid and res_ready on the same edge.
REQ-028 After reset, outputs SHALL be status=00, op_ready=(ctrlword==001), res_valid=0, result=0.
REQ-029 preset mid-operation SHALL discard the in-flight operand and any pending result; no partial result is ever presented.

Verification
REQ-030 WIDTH=8, n=4: preset; LOAD with op_valid, n=4; 4 ACCUM cycles; 1 DONE -> status goes 11,11,11,11,01 in sequence; result=10, res_valid=1.
REQ-031 n=255: 255 ACCUM cycles then DONE -> result=32640, no wrap; status[1]=0 only after the 255th ACCUM.
REQ-032 n=0 accepted in LOAD -> res_valid=1 and result=0 on the next cycle; status=00 throughout.
REQ-033 Backpressure: result=10 pending with res_ready=0 for 5 cycles, op_valid=1 in LOAD -> op_ready=0, result held at 10.
  - res_ready=1 -> res_valid clears; op_ready=1 next cycle.
REQ-034 preset after 2 ACCUM cycles of n=4 (acc=7, cnt=2) -> all state zero, status=00.
  - A subsequent n=3 run yields result=6.
REQ-035 ctrlword=011 or 000 during ACCUM for 3 cycles -> cnt and acc unchanged.
  - Resuming 010 completes n=4 with result=10.

Source files
------------

// File: rtl/gauss_datapath.sv
// Gauss sum 1+2+...+n datapath steered by a one-hot LOAD/ACCUM/DONE control word.
// Latency n+1 edges after operand accept (0 for n=0); single result buffer, no operand taken while a result waits.
module gauss_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               preset,
  input  logic [2:0]         ctrlword,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   op_n,
  output logic [1:0]         status,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [2:0] CMD_LOAD  = 3'b001;
  localparam logic [2:0] CMD_ACCUM = 3'b010;
  localparam logic [2:0] CMD_DONE  = 3'b100;

  logic [WIDTH-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic               held;

  logic is_load;
  logic is_accum;
  logic is_done;
  logic op_accept;
  logic zero_accept;
  logic accum_step;
  logic complete;
  logic res_taken;

  // Any non-one-hot word matches none of these, so every register freezes.
  assign is_load  = (ctrlword == CMD_LOAD);
  assign is_accum = (ctrlword == CMD_ACCUM);
  assign is_done  = (ctrlword == CMD_DONE);

  assign op_ready    = is_load & ~held & ~res_valid;
  assign op_accept   = op_valid & op_ready;
  assign zero_accept = op_accept & (op_n == '0);
  assign accum_step  = is_accum & (cnt != '0);
  assign complete    = is_done & held & ~res_valid;
  assign res_taken   = res_valid & res_ready;

  assign status = {held & (cnt != '0), held};

  always_ff @(posedge clk) begin
    if (preset) begin
      cnt       <= '0;
      acc       <= '0;
      held      <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
    end else begin
      if (op_accept) begin
        if (op_n != '0) begin
          cnt  <= op_n;
          acc  <= '0;
          held <= 1'b1;
        end else begin
          result <= '0;
        end
      end
      if (accum_step) begin
        acc <= acc + {{WIDTH{1'b0}}, cnt};
        cnt <= cnt - WIDTH'(1);
      end
      if (complete) begin
        result <= acc;
        held   <= 1'b0;
      end
      // Completions require res_valid=0, so setting and clearing never coincide.
      if (complete | zero_accept) begin
        res_valid <= 1'b1;
      end else if (res_taken) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gauss_datapath.sv
// Bench for gauss_datapath: triangular-number model checked every cycle plus directed literal checks.
module tb_gauss_datapath;

  logic        clk = 1'b0;
  logic        preset;
  logic [2:0]  ctrlword;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_n;
  logic [1:0]  status;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  gauss_datapath #(.WIDTH(8)) dut (
    .clk       (clk),
    .preset    (preset),
    .ctrlword  (ctrlword),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_n      (op_n),
    .status    (status),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int tri_sum(input int x);
    return x * (x + 1) / 2;
  endfunction

  // Model: operand n, number of ACCUM steps taken, and the pending result.
  bit m_init = 0;
  bit m_held, m_rv;
  int m_n, m_steps, m_res;

  wire m_accept = (ctrlword == 3'b001) && op_valid && !m_held && !m_rv;
  wire m_accum  = (ctrlword == 3'b010) && m_held && (m_steps < m_n);
  wire m_comp   = (ctrlword == 3'b100) && m_held && !m_rv;

  always @(posedge clk) begin
    if (preset) begin
      m_init  <= 1;
      m_held  <= 0;
      m_rv    <= 0;
      m_res   <= 0;
      m_n     <= 0;
      m_steps <= 0;
    end else if (m_init) begin
      if (m_rv && res_ready) m_rv <= 0;
      if (m_accept) begin
        if (op_n != 0) begin
          m_n     <= op_n;
          m_steps <= 0;
          m_held  <= 1;
        end else begin
          m_res <= 0;
          m_rv  <= 1;
        end
      end
      if (m_accum) m_steps <= m_steps + 1;
      if (m_comp) begin
        // Sum of the top m_steps terms of 1..n.
        m_res  <= tri_sum(m_n) - tri_sum(m_n - m_steps);
        m_rv   <= 1;
        m_held <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_op_ready", op_ready, (ctrlword == 3'b001) && !m_held && !m_rv);
      chk("m_status", status, {(m_held && (m_steps < m_n)), m_held});
      chk("m_res_valid", res_valid, m_rv);
      chk("m_result", result, m_res);
      // A held operand alongside a valid result would mean a completion met a handshake.
      total++;
      if (status[0] && res_valid) begin
        bad++;
        $display("FAIL collision held=%0d res_valid=%0d at %0t", status[0], res_valid, $time);
      end
    end
  end

  task automatic step(input logic [2:0] c, input logic ov, input logic [7:0] n,
                      input logic rr, input logic pr);
    ctrlword  = c;
    op_valid  = ov;
    op_n      = n;
    res_ready = rr;
    preset    = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic accum(input int k);
    for (int i = 0; i < k; i++) step(3'b010, 0, 8'd0, 0, 0);
  endtask

  initial begin
    preset = 1; ctrlword = 3'b001; op_valid = 0; op_n = 0; res_ready = 0;
    step(3'b001, 0, 8'd0, 0, 1);
    step(3'b001, 0, 8'd0, 0, 1);
    step(3'b001, 0, 8'd0, 0, 0);
    chk("rst_status", status, 0);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_result", result, 0);

    // n=4 basic run
    step(3'b001, 1, 8'd4, 0, 0);
    chk("n4_load_status", status, 3);
    for (int i = 1; i <= 4; i++) begin
      accum(1);
      chk("n4_accum_status", status, (i < 4) ? 3 : 1);
    end
    step(3'b100, 0, 8'd0, 0, 0);
    chk("n4_res_valid", res_valid, 1);
    chk("n4_result", result, 10);
    chk("n4_done_status", status, 0);

    // Backpressure with a pending result
    for (int i = 0; i < 5; i++) begin
      step(3'b001, 1, 8'd4, 0, 0);
      chk("bp_op_ready", op_ready, 0);
      chk("bp_result", result, 10);
    end
    step(3'b001, 1, 8'd4, 1, 0);
    chk("bp_released", res_valid, 0);
    chk("bp_op_ready_after", op_ready, 1);
    chk("bp_result_kept", result, 10);

    // Preset mid-operation, then n=3
    step(3'b001, 1, 8'd4, 0, 0);
    accum(2);
    step(3'b010, 0, 8'd0, 0, 1);
    chk("mid_rst_status", status, 0);
    chk("mid_rst_result", result, 0);
    step(3'b001, 1, 8'd3, 0, 0);
    accum(3);
    step(3'b100, 0, 8'd0, 1, 0);
    chk("n3_result", result, 6);
    step(3'b000, 0, 8'd0, 1, 0);
    chk("n3_taken", res_valid, 0);

    // Illegal control words freeze state
    step(3'b001, 1, 8'd4, 0, 0);
    accum(1);
    for (int i = 0; i < 3; i++) step(3'b011, 1, 8'd9, 0, 0);
    chk("freeze011_op_ready", op_ready, 0);
    for (int i = 0; i < 3; i++) step(3'b000, 1, 8'd9, 0, 0);
    chk("freeze_status", status, 3);
    accum(3);
    chk("freeze_resume_status", status, 1);
    step(3'b100, 0, 8'd0, 1, 0);
    chk("freeze_result", result, 10);
    step(3'b000, 0, 8'd0, 1, 0);

    // Early DONE after 2 ACCUMs of n=4 gives 4+3; leftover count must stay invisible
    step(3'b001, 1, 8'd4, 0, 0);
    accum(2);
    step(3'b100, 0, 8'd0, 0, 0);
    chk("early_result", result, 7);
    accum(2);
    chk("early_status", status, 0);
    chk("early_result_stable", result, 7);
    step(3'b100, 0, 8'd0, 1, 0);
    chk("early_done_noop", result, 7);
    step(3'b000, 0, 8'd0, 0, 0);

    // n=255, no wrap
    step(3'b001, 1, 8'd255, 0, 0);
    accum(254);
    chk("n255_status_254", status, 3);
    accum(1);
    chk("n255_status_255", status, 1);
    step(3'b100, 0, 8'd0, 0, 0);
    chk("n255_result", result, 32640);
    chk("n255_model", m_res, 32640);
    step(3'b000, 0, 8'd0, 1, 0);

    // n=0 completes on the accept edge
    step(3'b001, 1, 8'd0, 0, 0);
    chk("n0_res_valid", res_valid, 1);
    chk("n0_result", result, 0);
    chk("n0_status", status, 0);
    step(3'b001, 1, 8'd5, 0, 0);
    chk("n0_blocks", status, 0);
    // Preset discards the pending result
    step(3'b000, 0, 8'd0, 0, 1);
    chk("n0_rst_valid", res_valid, 0);
    step(3'b000, 0, 8'd0, 0, 0);
    step(3'b000, 0, 8'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
